rom_cargable: RTL and testbench

- Parametrised multi-port read-only memory; next generation of the 16x32 dual-port ROM.
- Contents come from a streaming load interface after reset, so there is no file-based initialisation.
- Reads are registered, with 1-cycle latency and a per-port valid flag.
- Sits beside the register file; serves instruction/constant fetch to the datapath.

---
 rtl/rom_cargable_if.sv | 26 ++
 rtl/rom_cargable.sv | 75 +++++++
 tb/tb_rom_cargable.sv | 218 +++++++++++++++++++++
 3 files changed

// File: rtl/rom_cargable_if.sv
// Load stream and multi-port read bus of the loadable ROM.
// master drives loads and read requests; slave is the ROM itself.
interface rom_cargable_if #(
    parameter int W  = 32,
    parameter int AW = 4,
    parameter int NP = 2
);
    logic             CargaVal;
    logic [W-1:0]     CargaDato;
    logic             Listo;
    logic [NP-1:0]    Lee;
    logic [NP*AW-1:0] Dir;
    logic [NP*W-1:0]  DatoL;
    logic [NP-1:0]    Valido;
    logic [NP-1:0]    Error;

    modport master (
        output CargaVal, CargaDato, Lee, Dir,
        input  Listo, DatoL, Valido, Error
    );

    modport slave (
        input  CargaVal, CargaDato, Lee, Dir,
        output Listo, DatoL, Valido, Error
    );
endinterface

// File: rtl/rom_cargable.sv
// Multi-port ROM filled once from a word stream after reset, then read-only.
// Each port has a registered read path: data, valid and out-of-range flag.
module rom_cargable #(
    parameter int W     = 32,
    parameter int DEPTH = 16,
    parameter int AW    = 4,
    parameter int NP    = 2
) (
    input  logic           clk,
    input  logic           rst,
    rom_cargable_if.slave  bus
);
    localparam logic [0:0] CARGA = 1'b0;
    localparam logic [0:0] LISTO = 1'b1;

    // Compared at AW+1 bits so DEPTH == 2**AW neither wraps nor flags errors.
    localparam logic [AW:0] LAST  = (AW+1)'(DEPTH - 1);
    localparam logic [AW:0] LIMIT = (AW+1)'(DEPTH);

    logic [W-1:0]    mem [DEPTH];
    logic [0:0]      state;
    logic [AW:0]     ptr;
    logic            load_en;
    logic [NP-1:0]   valido_q;
    logic [NP-1:0]   error_q;
    logic [NP*W-1:0] dato_q;

    assign load_en = (state == CARGA) && bus.CargaVal;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= CARGA;
            ptr   <= '0;
        end else if (load_en) begin
            ptr <= ptr + (AW+1)'(1);
            if (ptr == LAST)
                state <= LISTO;
        end
    end

    // Array deliberately has no reset: contents survive rst until overwritten.
    always_ff @(posedge clk) begin
        if (load_en)
            mem[ptr[AW-1:0]] <= bus.CargaDato;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valido_q <= '0;
            error_q  <= '0;
            dato_q   <= '0;
        end else begin
            for (int i = 0; i < NP; i++) begin
                if ((state == LISTO) && bus.Lee[i]) begin
                    valido_q[i] <= 1'b1;
                    if ({1'b0, bus.Dir[i*AW +: AW]} < LIMIT) begin
                        dato_q[i*W +: W] <= mem[bus.Dir[i*AW +: AW]];
                        error_q[i]       <= 1'b0;
                    end else begin
                        dato_q[i*W +: W] <= '0;
                        error_q[i]       <= 1'b1;
                    end
                end else begin
                    valido_q[i] <= 1'b0;
                    error_q[i]  <= 1'b0;
                end
            end
        end
    end

    assign bus.Listo  = (state == LISTO);
    assign bus.Valido = valido_q;
    assign bus.Error  = error_q;
    assign bus.DatoL  = dato_q;
endmodule

// File: tb/tb_rom_cargable.sv
// Bench for rom_cargable: a 16-word instance checked cycle by cycle against an
// array model, plus a 12-word instance for out-of-range reads.
module tb_rom_cargable;
    logic clk = 1'b0;
    logic rst;
    logic rst12;

    always #5 clk = ~clk;

    rom_cargable_if #(.W(32), .AW(4), .NP(2)) bus16 ();
    rom_cargable_if #(.W(32), .AW(4), .NP(2)) bus12 ();

    rom_cargable #(.W(32), .DEPTH(16), .AW(4), .NP(2)) dut16 (
        .clk (clk), .rst (rst),   .bus (bus16.slave));
    rom_cargable #(.W(32), .DEPTH(12), .AW(4), .NP(2)) dut12 (
        .clk (clk), .rst (rst12), .bus (bus12.slave));

    int n_assert = 0;
    int n_fail   = 0;

    logic [31:0] m_mem [16];
    int          m_ptr;
    bit          m_listo;
    logic [1:0]  m_vld;
    logic [1:0]  m_err;
    logic [31:0] m_dat [2];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_ptr   = 0;
        m_listo = 0;
        m_vld   = 2'b00;
        m_err   = 2'b00;
        m_dat[0] = '0;
        m_dat[1] = '0;
    endtask

    task automatic check_all();
        chk("listo",  {63'd0, bus16.Listo}, {63'd0, m_listo});
        chk("valido", {62'd0, bus16.Valido}, {62'd0, m_vld});
        chk("error",  {62'd0, bus16.Error},  {62'd0, m_err});
        chk("dato0",  {32'd0, bus16.DatoL[31:0]},  {32'd0, m_dat[0]});
        chk("dato1",  {32'd0, bus16.DatoL[63:32]}, {32'd0, m_dat[1]});
    endtask

    // One clock edge: advance the model from the inputs in force, then compare.
    task automatic cyc();
        int a;
        @(posedge clk);
        for (int p = 0; p < 2; p++) begin
            if (m_listo && bus16.Lee[p]) begin
                a = int'(bus16.Dir[p*4 +: 4]);
                m_vld[p] = 1'b1;
                if (a < 16) begin
                    m_dat[p] = m_mem[a];
                    m_err[p] = 1'b0;
                end else begin
                    m_dat[p] = '0;
                    m_err[p] = 1'b1;
                end
            end else begin
                m_vld[p] = 1'b0;
                m_err[p] = 1'b0;
            end
        end
        if (!m_listo && bus16.CargaVal) begin
            m_mem[m_ptr] = bus16.CargaDato;
            if (m_ptr == 15) m_listo = 1;
            m_ptr++;
        end
        #1;
        check_all();
    endtask

    // Called one time unit after an edge; pulses rst between edges.
    task automatic pulse_reset();
        #2 rst = 1'b1;
        #1;
        model_reset();
        check_all();
        #2 rst = 1'b0;
    endtask

    task automatic load16(input logic [31:0] base);
        for (int k = 0; k < 16; k++) begin
            bus16.CargaVal  = 1'b1;
            bus16.CargaDato = base + 32'(k);
            cyc();
            if (k == 14) chk("listo_before_last", {63'd0, bus16.Listo}, 64'd0);
        end
        bus16.CargaVal = 1'b0;
        chk("listo_after_last", {63'd0, bus16.Listo}, 64'd1);
    endtask

    initial begin
        rst = 1'b1;
        rst12 = 1'b1;
        bus16.CargaVal = 0; bus16.CargaDato = '0; bus16.Lee = '0; bus16.Dir = '0;
        bus12.CargaVal = 0; bus12.CargaDato = '0; bus12.Lee = '0; bus12.Dir = '0;
        for (int k = 0; k < 16; k++) m_mem[k] = 'x;
        model_reset();
        #3;
        check_all();
        chk("r12_listo",  {63'd0, bus12.Listo},  64'd0);
        chk("r12_valido", {62'd0, bus12.Valido}, 64'd0);
        rst12 = 1'b0;

        // DEPTH=12 instance: in-range and out-of-range reads on the same edge
        @(posedge clk); #1;
        for (int k = 0; k < 12; k++) begin
            bus12.CargaVal  = 1'b1;
            bus12.CargaDato = 32'hC000_0000 + 32'(k);
            @(posedge clk); #1;
            if (k == 10) chk("d12_listo_early", {63'd0, bus12.Listo}, 64'd0);
        end
        bus12.CargaVal = 1'b0;
        chk("d12_listo", {63'd0, bus12.Listo}, 64'd1);
        bus12.Lee = 2'b11;
        bus12.Dir = {4'd13, 4'd11};
        @(posedge clk); #1;
        chk("d12_valido", {62'd0, bus12.Valido}, 64'd3);
        chk("d12_error",  {62'd0, bus12.Error},  64'd2);
        chk("d12_dato1",  {32'd0, bus12.DatoL[63:32]}, 64'd0);
        chk("d12_dato0",  {32'd0, bus12.DatoL[31:0]},  64'hC000_000B);
        bus12.Lee = 2'b00;

        // DEPTH=16: load while Lee is held, including on the final load edge
        rst = 1'b0;
        bus16.Lee = 2'b11;
        bus16.Dir = {4'd2, 4'd9};
        load16(32'hA000_0000);
        chk("no_valid_final_edge", {62'd0, bus16.Valido}, 64'd0);
        chk("dato_still_zero", {32'd0, bus16.DatoL[31:0]}, 64'd0);

        bus16.Lee = 2'b01;
        bus16.Dir = {4'd0, 4'd5};
        cyc();
        chk("rd5_valid", {62'd0, bus16.Valido}, 64'd1);
        chk("rd5_data",  {32'd0, bus16.DatoL[31:0]}, 64'hA000_0005);

        // loads after Listo are ignored
        bus16.Lee = 2'b00;
        bus16.CargaVal = 1'b1;
        bus16.CargaDato = 32'hFFFF_FFFF;
        repeat (4) cyc();
        bus16.CargaVal = 1'b0;
        bus16.Lee = 2'b01;
        bus16.Dir = {4'd0, 4'd0};
        cyc();
        chk("frozen_word0", {32'd0, bus16.DatoL[31:0]}, 64'hA000_0000);

        // both ports on the same address, back to back
        bus16.Lee = 2'b11;
        bus16.Dir = {4'd7, 4'd7};
        repeat (8) begin
            cyc();
            chk("same_valid", {62'd0, bus16.Valido}, 64'd3);
            chk("same_dato1", {32'd0, bus16.DatoL[63:32]}, 64'hA000_0007);
        end
        bus16.Lee = 2'b10;
        cyc();
        chk("drop_valid", {62'd0, bus16.Valido}, 64'd2);
        chk("drop_hold0", {32'd0, bus16.DatoL[31:0]}, 64'hA000_0007);

        // random reads, load attempts ignored
        repeat (200) begin
            bus16.Lee       = 2'($urandom);
            bus16.Dir       = 8'($urandom);
            bus16.CargaVal  = 1'($urandom);
            bus16.CargaDato = $urandom;
            cyc();
        end

        // reset during an in-flight read drops it immediately
        bus16.CargaVal = 1'b0;
        bus16.Lee = 2'b11;
        bus16.Dir = {4'd1, 4'd4};
        cyc();
        chk("pre_rst_valid", {62'd0, bus16.Valido}, 64'd3);
        bus16.Lee = 2'b00;
        pulse_reset();
        chk("rst_valid_clear", {62'd0, bus16.Valido}, 64'd0);

        // reset mid-load, then a full reload
        @(posedge clk); #1;
        for (int k = 0; k < 6; k++) begin
            bus16.CargaVal  = 1'b1;
            bus16.CargaDato = 32'hD000_0000 + 32'(k);
            cyc();
        end
        bus16.CargaVal = 1'b0;
        pulse_reset();
        @(posedge clk); #1;
        bus16.Lee = 2'b11;
        bus16.Dir = {4'd3, 4'd3};
        load16(32'hB000_0000);
        bus16.Lee = 2'b01;
        bus16.Dir = {4'd0, 4'd3};
        cyc();
        chk("reload_rd3", {32'd0, bus16.DatoL[31:0]}, 64'hB000_0003);

        repeat (60) begin
            bus16.Lee = 2'($urandom);
            bus16.Dir = 8'($urandom);
            cyc();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
